// File: rtl/elec_layer_tx_driver.sv
// Single-lane USB4 electrical-layer transmit driver: LSB-first byte serializer
// plus SLOS1 (PRBS11) / TS1 / TS2 ordered-set generator with repetition count.
module elec_layer_tx_driver #(
    parameter logic [31:0] TS1_PATTERN = 32'h1E0F_00A5,
    parameter logic [31:0] TS2_PATTERN = 32'h1E0F_00B4,
    parameter int          SLOS_LEN    = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       os_req,
    input  logic [1:0] os_type,
    input  logic [7:0] os_count,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       lane_tx,
    output logic       lane_idle,
    output logic       os_busy,
    output logic       os_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_OS   = 2'd2
    } state_t;

    localparam logic [10:0] LFSR_SEED = 11'h7FF;
    localparam logic [10:0] SLOS_LAST = 11'(SLOS_LEN - 1);
    localparam logic [10:0] TS_LAST   = 11'd31;
    localparam logic [10:0] BYTE_LAST = 11'd7;
    localparam logic [1:0]  OS_SLOS   = 2'd1;
    localparam logic [1:0]  OS_TS2    = 2'd3;

    function automatic logic [10:0] lfsr_step(input logic [10:0] v);
        return {v[9:0], v[10] ^ v[8]};
    endfunction

    function automatic logic ts_bit(input logic [1:0] t, input logic [4:0] idx);
        return (t == OS_TS2) ? TS2_PATTERN[idx] : TS1_PATTERN[idx];
    endfunction

    state_t      state_r, next_state_s;
    logic [7:0]  shift_r, shift_n;
    logic [10:0] bit_cnt_r, bit_cnt_n, bit_inc_s;
    logic [7:0]  rep_cnt_r, rep_cnt_n;
    logic [10:0] lfsr_r, lfsr_n;
    logic [1:0]  os_type_r, os_type_n, pend_type_r, pend_type_n, sel_type_s;
    logic [7:0]  os_count_r, os_count_n, pend_count_r, pend_count_n, sel_count_s;
    logic        pend_r, pend_n;
    logic        lane_tx_r, lane_tx_n, lane_idle_r, lane_idle_n;
    logic        data_ready_r, data_ready_n, os_busy_r, os_busy_n, os_done_r, os_done_n;
    logic        boundary_s, req_new_s, start_os_s, accept_s;
    logic        rep_end_s, os_end_s, first_bit_s, restart_bit_s, os_next_bit_s;

    assign data_ready = data_ready_r;
    assign lane_tx    = lane_tx_r;
    assign lane_idle  = lane_idle_r;
    assign os_busy    = os_busy_r;
    assign os_done    = os_done_r;

    // A request taken at a byte boundary (or from idle) beats a coincident byte handshake.
    assign bit_inc_s   = bit_cnt_r + 11'd1;
    assign boundary_s  = (state_r == ST_IDLE) || ((state_r == ST_DATA) && (bit_cnt_r == BYTE_LAST));
    assign req_new_s   = os_req && (os_type != 2'd0) && !os_busy_r && !pend_r;
    assign start_os_s  = enable && boundary_s && (pend_r || req_new_s);
    assign accept_s    = enable && boundary_s && !start_os_s && data_valid && data_ready_r;
    assign sel_type_s  = pend_r ? pend_type_r : os_type;
    assign sel_count_s = pend_r ? pend_count_r : os_count;
    assign rep_end_s   = (state_r == ST_OS) &&
                         (bit_cnt_r == ((os_type_r == OS_SLOS) ? SLOS_LAST : TS_LAST));
    assign os_end_s    = rep_end_s && (rep_cnt_r == (os_count_r - 8'd1));
    assign first_bit_s   = (sel_type_s == OS_SLOS) ? LFSR_SEED[10] : ts_bit(sel_type_s, 5'd0);
    assign restart_bit_s = (os_type_r == OS_SLOS) ? LFSR_SEED[10] : ts_bit(os_type_r, 5'd0);
    // The final bit of every SLOS repetition is a forced 0 after 2047 PRBS bits.
    assign os_next_bit_s = (os_type_r == OS_SLOS) ?
                           ((bit_inc_s == SLOS_LAST) ? 1'b0 : lfsr_r[10]) :
                           ts_bit(os_type_r, bit_inc_s[4:0]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        if (!enable) begin
            next_state_s = ST_IDLE;
        end else if (start_os_s) begin
            next_state_s = ST_OS;
        end else if (accept_s) begin
            next_state_s = ST_DATA;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = ST_IDLE;
                ST_DATA: next_state_s = (bit_cnt_r == BYTE_LAST) ? ST_IDLE : ST_DATA;
                ST_OS:   next_state_s = os_end_s ? ST_IDLE : ST_OS;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        lane_tx_n    = 1'b0;
        lane_idle_n  = 1'b0;
        data_ready_n = 1'b0;
        os_busy_n    = 1'b0;
        os_done_n    = 1'b0;
        shift_n      = shift_r;
        bit_cnt_n    = bit_cnt_r;
        rep_cnt_n    = rep_cnt_r;
        lfsr_n       = lfsr_r;
        os_type_n    = os_type_r;
        os_count_n   = os_count_r;
        pend_n       = pend_r;
        pend_type_n  = pend_type_r;
        pend_count_n = pend_count_r;
        if (!enable) begin
            lane_idle_n = 1'b1;
            bit_cnt_n   = 11'd0;
            rep_cnt_n   = 8'd0;
            pend_n      = 1'b0;
        end else if (start_os_s) begin
            os_type_n  = sel_type_s;
            os_count_n = (sel_count_s == 8'd0) ? 8'd1 : sel_count_s;
            bit_cnt_n  = 11'd0;
            rep_cnt_n  = 8'd0;
            lfsr_n     = lfsr_step(LFSR_SEED);
            lane_tx_n  = first_bit_s;
            os_busy_n  = 1'b1;
            pend_n     = 1'b0;
        end else if (accept_s) begin
            shift_n   = data_in;
            bit_cnt_n = 11'd0;
            lane_tx_n = data_in[0];
        end else begin
            case (state_r)
                ST_DATA: begin
                    if (bit_cnt_r == BYTE_LAST) begin
                        bit_cnt_n    = 11'd0;
                        data_ready_n = 1'b1;
                    end else begin
                        bit_cnt_n = bit_inc_s;
                        lane_tx_n = shift_r[bit_inc_s[2:0]];
                        if (req_new_s) begin
                            pend_n       = 1'b1;
                            pend_type_n  = os_type;
                            pend_count_n = os_count;
                        end else begin
                            pend_n = pend_r;
                        end
                        data_ready_n = (bit_inc_s == BYTE_LAST) && !pend_n;
                    end
                end
                ST_OS: begin
                    if (os_end_s) begin
                        os_done_n    = 1'b1;
                        data_ready_n = 1'b1;
                        bit_cnt_n    = 11'd0;
                        rep_cnt_n    = 8'd0;
                    end else if (rep_end_s) begin
                        rep_cnt_n = rep_cnt_r + 8'd1;
                        bit_cnt_n = 11'd0;
                        lfsr_n    = lfsr_step(LFSR_SEED);
                        lane_tx_n = restart_bit_s;
                        os_busy_n = 1'b1;
                    end else begin
                        bit_cnt_n = bit_inc_s;
                        lfsr_n    = lfsr_step(lfsr_r);
                        lane_tx_n = os_next_bit_s;
                        os_busy_n = 1'b1;
                    end
                end
                default: begin
                    data_ready_n = 1'b1;
                end
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_tx_r    <= 1'b0;
            lane_idle_r  <= 1'b1;
            data_ready_r <= 1'b0;
            os_busy_r    <= 1'b0;
            os_done_r    <= 1'b0;
            shift_r      <= 8'd0;
            bit_cnt_r    <= 11'd0;
            rep_cnt_r    <= 8'd0;
            lfsr_r       <= LFSR_SEED;
            os_type_r    <= 2'd0;
            os_count_r   <= 8'd0;
            pend_r       <= 1'b0;
            pend_type_r  <= 2'd0;
            pend_count_r <= 8'd0;
        end else begin
            lane_tx_r    <= lane_tx_n;
            lane_idle_r  <= lane_idle_n;
            data_ready_r <= data_ready_n;
            os_busy_r    <= os_busy_n;
            os_done_r    <= os_done_n;
            shift_r      <= shift_n;
            bit_cnt_r    <= bit_cnt_n;
            rep_cnt_r    <= rep_cnt_n;
            lfsr_r       <= lfsr_n;
            os_type_r    <= os_type_n;
            os_count_r   <= os_count_n;
            pend_r       <= pend_n;
            pend_type_r  <= pend_type_n;
            pend_count_r <= pend_count_n;
        end
    end

endmodule

// File: tb/tb_elec_layer_tx_driver.sv
// Bench for elec_layer_tx_driver: a bit-queue reference model checked every cycle,
// a table of ordered-set requests, hand-written corner sequences and random traffic.
module tb_elec_layer_tx_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       os_req = 1'b0;
    logic [1:0] os_type = 2'd0;
    logic [7:0] os_count = 8'd0;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;
    logic       data_ready, lane_tx, lane_idle, os_busy, os_done;

    int checks = 0;
    int passes = 0;

    localparam logic [31:0] TS1 = 32'h1E0F_00A5;
    localparam logic [31:0] TS2 = 32'h1E0F_00B4;

    elec_layer_tx_driver dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .os_req(os_req),
        .os_type(os_type), .os_count(os_count), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .lane_tx(lane_tx),
        .lane_idle(lane_idle), .os_busy(os_busy), .os_done(os_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    bit         slos[2048];
    bit         q[$];
    int         m_kind;          // 0 idle, 1 byte, 2 ordered set
    bit         m_pend;
    logic [1:0] m_ptype;
    logic [7:0] m_pcnt;
    bit         e_tx, e_idle, e_ready, e_busy, e_done;

    function automatic void build_slos();
        for (int k = 0; k < 11; k++) slos[k] = 1'b1;
        for (int k = 11; k < 2047; k++) slos[k] = slos[k-11] ^ slos[k-9];
        slos[2047] = 1'b0;
    endfunction

    task automatic model_reset();
        q.delete(); m_kind = 0; m_pend = 1'b0;
        e_tx = 1'b0; e_idle = 1'b1; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    endtask

    task automatic push_os(input logic [1:0] t, input logic [7:0] c);
        int reps;
        logic [31:0] pat;
        reps = (c == 8'd0) ? 1 : int'(c);
        pat  = (t == 2'd2) ? TS1 : TS2;
        for (int r = 0; r < reps; r++) begin
            if (t == 2'd1) for (int k = 0; k < 2048; k++) q.push_back(slos[k]);
            else for (int k = 0; k < 32; k++) q.push_back(pat[k]);
        end
    endtask

    task automatic model_step();
        bit req_ok;
        req_ok = os_req && (os_type != 2'd0) && !e_busy && !m_pend;
        e_done = 1'b0;
        if (!enable) begin
            q.delete(); m_kind = 0; m_pend = 1'b0;
            e_tx = 1'b0; e_idle = 1'b1; e_ready = 1'b0; e_busy = 1'b0;
        end else if (q.size() == 0 && m_kind == 2) begin
            e_done = 1'b1; e_busy = 1'b0; e_ready = 1'b1; e_tx = 1'b0; e_idle = 1'b0; m_kind = 0;
        end else if (q.size() == 0) begin
            e_idle = 1'b0;
            if (m_pend || req_ok) begin
                push_os(m_pend ? m_ptype : os_type, m_pend ? m_pcnt : os_count);
                m_pend = 1'b0; e_tx = q.pop_front(); e_busy = 1'b1; e_ready = 1'b0; m_kind = 2;
            end else if (data_valid && e_ready) begin
                for (int k = 0; k < 8; k++) q.push_back(data_in[k]);
                e_tx = q.pop_front(); e_ready = 1'b0; m_kind = 1;
            end else begin
                e_tx = 1'b0; e_ready = 1'b1; m_kind = 0;
            end
        end else begin
            e_tx = q.pop_front();
            if (m_kind == 1) begin
                if (req_ok) begin m_pend = 1'b1; m_ptype = os_type; m_pcnt = os_count; end
                e_ready = (q.size() == 0) && !m_pend;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        check("cycle_model", 32'({lane_tx, lane_idle, data_ready, os_busy, os_done}),
              32'({e_tx, e_idle, e_ready, e_busy, e_done}));
    end

    // ---------------- ordered-set table ----------------
    typedef struct {
        logic [1:0]  t;
        logic [7:0]  c;
        int          len;
        int          dones;
        logic [31:0] w0;
        int          off2;
    } os_vec_t;

    os_vec_t tbl[6];

    initial begin
        logic [15:0] vec16, rdy16;
        logic [31:0] w0, w2;
        logic [7:0]  vec8;
        int busy_n, done_n, rdy_n, first_busy;
        logic rdy7, post_bit;
        bit done_seen;

        tbl[0] = '{2'd2, 8'd2, 64,   1, 32'h1E0F_00A5, 32};
        tbl[1] = '{2'd3, 8'd0, 32,   1, 32'h1E0F_00B4, 0};
        tbl[2] = '{2'd0, 8'd3, 0,    0, 32'h0000_0000, 0};
        tbl[3] = '{2'd1, 8'd1, 2048, 1, 32'hE030_07FF, 0};
        tbl[4] = '{2'd1, 8'd2, 4096, 1, 32'hE030_07FF, 2048};
        tbl[5] = '{2'd3, 8'd1, 32,   1, 32'h1E0F_00B4, 0};
        build_slos();

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_values", 32'({lane_tx, lane_idle, data_ready, os_busy, os_done}), 32'h08);
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);
        check("enabled_idle", 32'({lane_tx, lane_idle, data_ready}), 32'h1);

        // Two bytes back to back.
        data_valid = 1'b1; data_in = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vec16[i] = lane_tx; rdy16[i] = data_ready;
            if (i == 0) data_in = 8'h3C;
            if (i == 8) data_valid = 1'b0;
        end
        check("byte_stream", 32'(vec16), 32'h3CA5);
        check("byte_ready_bit7", 32'(rdy16), 32'h8080);

        // Ordered-set table issued from idle.
        foreach (tbl[n]) begin
            repeat (2) @(negedge clk);
            os_req = 1'b1; os_type = tbl[n].t; os_count = tbl[n].c;
            busy_n = 0; done_n = 0; rdy_n = 0; first_busy = -1; w0 = 32'd0; w2 = 32'd0;
            for (int cyc = 0; cyc < tbl[n].len + 40; cyc++) begin
                @(negedge clk);
                os_req = 1'b0;
                if (os_busy) begin
                    if (first_busy < 0) first_busy = cyc;
                    if (busy_n < 32) w0[busy_n] = lane_tx;
                    if (tbl[n].off2 != 0 && busy_n >= tbl[n].off2 && busy_n < tbl[n].off2 + 32)
                        w2[busy_n - tbl[n].off2] = lane_tx;
                    if (data_ready) rdy_n++;
                    busy_n++;
                end
                if (os_done) done_n++;
            end
            check("os_busy_len", busy_n, tbl[n].len);
            check("os_done_count", done_n, tbl[n].dones);
            check("os_first_word", w0, tbl[n].w0);
            check("os_busy_start", first_busy, (tbl[n].len > 0) ? 0 : -1);
            check("os_ready_low", rdy_n, 0);
            if (tbl[n].off2 != 0) check("os_repeat_word", w2, tbl[n].w0);
        end

        // TS2 requested at bit 3 of a byte while another byte is offered.
        repeat (2) @(negedge clk);
        data_valid = 1'b1; data_in = 8'h5A;
        @(negedge clk);
        vec8[0] = lane_tx; data_in = 8'hFF;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            vec8[i] = lane_tx;
            if (i == 3) begin os_req = 1'b1; os_type = 2'd3; os_count = 8'd1; end
            if (i == 4) os_req = 1'b0;
            if (i == 7) rdy7 = data_ready;
        end
        check("midbyte_byte", 32'(vec8), 32'h5A);
        check("midbyte_ready_low", 32'(rdy7), 32'h0);
        @(negedge clk);
        check("ts2_starts", 32'({os_busy, lane_tx}), 32'h2);
        busy_n = 1; done_seen = 1'b0; post_bit = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (os_busy) busy_n++;
            if (done_seen && data_valid) begin post_bit = lane_tx; data_valid = 1'b0; end
            if (os_done) done_seen = 1'b1;
        end
        check("midbyte_ts2_len", busy_n, 32);
        check("byte_after_os", 32'(post_bit), 32'h1);

        // Enable dropped midway through TS1.
        os_req = 1'b1; os_type = 2'd2; os_count = 8'd3;
        @(negedge clk); os_req = 1'b0;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable_idle", 32'({lane_tx, lane_idle, data_ready, os_busy, os_done}), 32'h08);
        done_n = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin @(negedge clk); if (os_done) done_n++; end
        check("disable_no_done", done_n, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_ready", 32'({lane_idle, data_ready}), 32'h1);

        // A request while busy is ignored.
        os_req = 1'b1; os_type = 2'd2; os_count = 8'd1;
        busy_n = 0; done_n = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            os_req = (cyc == 10); os_type = 2'd1;
            if (os_busy) busy_n++;
            if (os_done) done_n++;
        end
        check("busy_req_len", busy_n, 32);
        check("busy_req_done", done_n, 1);

        // Asynchronous reset in the middle of an ordered set.
        os_req = 1'b1; os_type = 2'd3; os_count = 8'd2;
        @(negedge clk); os_req = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({lane_tx, lane_idle, data_ready, os_busy, os_done}), 32'h08);
        @(negedge clk); rst_n = 1'b1;
        done_n = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin @(negedge clk); if (os_done) done_n++; end
        check("reset_no_done", done_n, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 9) < 7);
            data_in    = 8'($urandom);
            os_req     = ($urandom_range(0, 149) == 0);
            os_type    = 2'($urandom_range(0, 3));
            os_count   = 8'($urandom_range(0, 2));
            enable     = ($urandom_range(0, 399) != 0);
        end
        os_req = 1'b0; data_valid = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
